// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Purpose  : Start/operand/result bundle between a requester and serial_adder.
// Revision : 1.0
// ============================================================================
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, a, b, c_in, sub,
        input  busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, a, b, c_in, sub,
        output busy, done, sum, c_out, overflow
    );
endinterface
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Digit-serial adder/subtractor, one DIGIT-bit slice per clock.
// Revision : 1.0
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    serial_adder_if.slave  bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_last = CW'(N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_psum;
    logic             r_carry;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_c_out;
    logic             r_overflow;

    logic [DIGIT:0]   w_dsum;
    logic             w_msb_cin;
    logic [WIDTH-1:0] w_psum_next;

    assign w_dsum = {1'b0, r_a_sr[DIGIT-1:0]}
                  + {1'b0, r_b_sr[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, r_carry};

    // Carry into the top bit of the slice, recovered from its sum bit.
    assign w_msb_cin = r_a_sr[DIGIT-1] ^ r_b_sr[DIGIT-1] ^ w_dsum[DIGIT-1];

    generate
        if (DIGIT < WIDTH) begin : g_psum_shift
            assign w_psum_next = {w_dsum[DIGIT-1:0], r_psum[WIDTH-1:DIGIT]};
        end else begin : g_psum_full
            assign w_psum_next = w_dsum[DIGIT-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_psum     <= '0;
            r_carry    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sum      <= '0;
            r_c_out    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a_sr  <= bus.a;
                        r_b_sr  <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.c_in ^ bus.sub;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sr  <= r_a_sr >> DIGIT;
                    r_b_sr  <= r_b_sr >> DIGIT;
                    r_psum  <= w_psum_next;
                    r_carry <= w_dsum[DIGIT];
                    r_count <= r_count + CW'(1);
                    if (r_count == c_last) begin
                        r_sum      <= w_psum_next;
                        r_c_out    <= w_dsum[DIGIT];
                        r_overflow <= w_msb_cin ^ w_dsum[DIGIT];
                        r_count    <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.c_out    = r_c_out;
    assign bus.overflow = r_overflow;
endmodule
`default_nettype wire
